ram1m_mmu: RTL and testbench

- 6809 paging unit upstream of the 1 MB RAM pair on the RAM1M CPLD.
- Maps each 16 KB CPU window (adr[15:14]) onto one of 64 physical 16 KB pages.
- Drives ramadrhi, ramcs0_b/ramcs1_b, ramoe_b and ramwe_b in place of fixed bank-0 decoding.
- Page registers are double-buffered (shadow plus active) so code can remap its own window atomically; each window has a write-protect bit with a sticky fault flag.

---
 rtl/ram1m_mmu.sv | 103 ++++++++++
 tb/tb_ram1m_mmu.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/ram1m_mmu.sv
// ram1m_mmu: 6809 paging unit mapping four 16 KB CPU windows onto 64 physical RAM pages
module ram1m_mmu #(
    parameter logic [11:0] IO_BASE  = 12'hBFF,
    parameter logic [2:0]  HOLE_TOP = 3'b101
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic [15:0] adr,
    input  logic        rnw,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    output logic        dout_oe,
    output logic [4:0]  ramadrhi,
    output logic        ramcs0_b,
    output logic        ramcs1_b,
    output logic        ramoe_b,
    output logic        ramwe_b,
    output logic        map_en,
    output logic        wp_fault
);
    logic [5:0] r_shadow [4];
    logic [5:0] r_active [4];
    logic       r_map_en;
    logic [3:0] r_wp;
    logic       r_wp_fault;
    logic       w_sel;
    logic       w_wr;
    logic       w_hole;
    logic [1:0] w_win;
    logic [2:0] w_off;
    logic [5:0] w_pp;
    logic       w_wp_hit;
    logic       w_stat_rd;
    logic       w_pending;
    logic [7:0] w_rd;
    logic       w_unused;

    assign w_sel     = (adr[15:4] == IO_BASE) & ~adr[3];
    assign w_wr      = w_sel & ~rnw;
    assign w_hole    = (adr[15:13] == HOLE_TOP);
    assign w_win     = adr[15:14];
    assign w_off     = adr[2:0];
    assign w_pp      = r_map_en ? r_active[w_win] : {4'b0000, w_win};
    assign w_wp_hit  = r_map_en & r_wp[w_win] & ~w_hole & ~rnw;
    assign w_stat_rd = w_sel & rnw & (w_off == 3'd5);
    assign w_unused  = &{1'b0, din[3:2]};

    assign ramadrhi = w_pp[4:0];
    assign ramcs0_b = w_hole | w_pp[5];
    assign ramcs1_b = w_hole | ~w_pp[5];
    assign ramoe_b  = ~rnw;
    assign ramwe_b  = rnw | ~clk | w_wp_hit;
    assign map_en   = r_map_en;
    assign wp_fault = r_wp_fault;
    assign dout_oe  = w_sel & rnw & clk & reset_b;
    assign dout     = (reset_b & w_sel) ? w_rd : 8'h00;

    // A remap is pending while any shadow page differs from its active copy
    always_comb begin
        w_pending = 1'b0;
        for (int i = 0; i < 4; i++)
            if (r_shadow[i] != r_active[i]) w_pending = 1'b1;
    end

    // Register readback mux; COMMIT and unused bits read as zero
    always_comb begin
        w_rd = 8'h00;
        case (w_off)
            3'd0, 3'd1, 3'd2, 3'd3: w_rd = {2'b00, r_shadow[w_off[1:0]]};
            3'd4:                   w_rd = {r_wp, 3'b000, r_map_en};
            3'd5:                   w_rd = {6'b000000, w_pending, r_wp_fault};
            default:                w_rd = 8'h00;
        endcase
    end

    // Page, control and commit registers, updated on the E falling edge
    always_ff @(negedge clk or negedge reset_b) begin
        if (!reset_b) begin
            for (int i = 0; i < 4; i++) begin
                r_shadow[i] <= 6'(i);
                r_active[i] <= 6'(i);
            end
            r_map_en <= 1'b0;
            r_wp     <= 4'h0;
        end else if (w_wr) begin
            if (!w_off[2]) begin
                r_shadow[w_off[1:0]] <= din[5:0];
            end else if (w_off[1:0] == 2'd0) begin
                r_map_en <= din[0];
                r_wp     <= din[7:4];
                if (din[1])
                    for (int i = 0; i < 4; i++) r_active[i] <= r_shadow[i];
            end
        end
    end

    // Sticky write-protect fault: a blocked write sets it, a STATUS read clears it, set wins
    always_ff @(negedge clk or negedge reset_b) begin
        if (!reset_b)       r_wp_fault <= 1'b0;
        else if (w_wp_hit)  r_wp_fault <= 1'b1;
        else if (w_stat_rd) r_wp_fault <= 1'b0;
    end
endmodule

// File: tb/tb_ram1m_mmu.sv
// tb_ram1m_mmu: directed self-checking bench for the ram1m_mmu paging unit
module tb_ram1m_mmu;
    logic        clk = 1'b0;
    logic        reset_b = 1'b0;
    logic [15:0] adr = 16'h0000;
    logic        rnw = 1'b1;
    logic [7:0]  din = 8'h00;
    logic [7:0]  dout;
    logic        dout_oe;
    logic [4:0]  ramadrhi;
    logic        ramcs0_b, ramcs1_b, ramoe_b, ramwe_b, map_en, wp_fault;
    int          checks = 0;
    int          failures = 0;

    ram1m_mmu dut (
        .clk(clk), .reset_b(reset_b), .adr(adr), .rnw(rnw), .din(din),
        .dout(dout), .dout_oe(dout_oe), .ramadrhi(ramadrhi),
        .ramcs0_b(ramcs0_b), .ramcs1_b(ramcs1_b), .ramoe_b(ramoe_b),
        .ramwe_b(ramwe_b), .map_en(map_en), .wp_fault(wp_fault)
    );

    always #10 clk = ~clk;

    // Start a bus cycle in E-low; the previous cycle ends at this falling edge
    task automatic drive(input logic [15:0] a, input logic r, input logic [7:0] d);
        @(negedge clk);
        #1;
        adr = a;
        rnw = r;
        din = d;
    endtask

    // Move into the E-high phase of the current cycle for sampling
    task automatic hi();
        @(posedge clk);
        #2;
    endtask

    task automatic go(input logic [15:0] a, input logic r, input logic [7:0] d);
        drive(a, r, d);
        hi();
    endtask

    task automatic test_reset();
        logic [7:0] exp_rb [6];
        exp_rb = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h00, 8'h00};
        adr = 16'hBFF1;
        rnw = 1'b1;
        hi();
        checks++; if (dout !== 8'h00) begin failures++; $display("FAIL rst_dout got=%h exp=00", dout); end
        checks++; if (dout_oe !== 1'b0) begin failures++; $display("FAIL rst_dout_oe got=%b exp=0", dout_oe); end
        checks++; if (map_en !== 1'b0 || wp_fault !== 1'b0) begin failures++; $display("FAIL rst_flags got=%b%b exp=00", map_en, wp_fault); end
        @(negedge clk);
        #1 reset_b = 1'b1;
        for (int i = 0; i < 6; i++) begin
            go(16'hBFF0 + 16'(i), 1'b1, 8'h00);
            checks++; if (dout !== exp_rb[i]) begin failures++; $display("FAIL rst_readback%0d got=%h exp=%h", i, dout, exp_rb[i]); end
            checks++; if (dout_oe !== 1'b1) begin failures++; $display("FAIL rst_read_oe%0d got=%b exp=1", i, dout_oe); end
        end
        go(16'h4123, 1'b1, 8'h00);
        checks++; if ({ramcs0_b, ramcs1_b, ramadrhi} !== 7'b01_00001) begin failures++; $display("FAIL rst_ident got=%b%b %b exp=01 00001", ramcs0_b, ramcs1_b, ramadrhi); end
        checks++; if (ramoe_b !== 1'b0 || ramwe_b !== 1'b1) begin failures++; $display("FAIL rst_oe_we got=%b%b exp=01", ramoe_b, ramwe_b); end
    endtask

    task automatic test_commit();
        go(16'hBFF1, 1'b0, 8'h25);
        go(16'hBFF5, 1'b1, 8'h00);
        checks++; if (dout !== 8'h02) begin failures++; $display("FAIL pend_status got=%h exp=02", dout); end
        go(16'h4000, 1'b1, 8'h00);
        checks++; if ({ramcs0_b, ramcs1_b, ramadrhi} !== 7'b01_00001) begin failures++; $display("FAIL precommit_map got=%b%b %b exp=01 00001", ramcs0_b, ramcs1_b, ramadrhi); end
        go(16'hBFF4, 1'b0, 8'h03);
        go(16'h4000, 1'b1, 8'h00);
        checks++; if ({ramcs0_b, ramcs1_b, ramadrhi} !== 7'b10_00101) begin failures++; $display("FAIL commit_map got=%b%b %b exp=10 00101", ramcs0_b, ramcs1_b, ramadrhi); end
        checks++; if (map_en !== 1'b1) begin failures++; $display("FAIL commit_map_en got=%b exp=1", map_en); end
        go(16'hBFF5, 1'b1, 8'h00);
        checks++; if (dout !== 8'h00) begin failures++; $display("FAIL commit_status got=%h exp=00", dout); end
        go(16'hBFF4, 1'b1, 8'h00);
        checks++; if (dout !== 8'h01) begin failures++; $display("FAIL ctrl_readback got=%h exp=01", dout); end
        go(16'hBFF1, 1'b1, 8'h00);
        checks++; if (dout !== 8'h25) begin failures++; $display("FAIL page1_readback got=%h exp=25", dout); end
        go(16'hC000, 1'b1, 8'h00);
        checks++; if ({ramcs0_b, ramcs1_b, ramadrhi} !== 7'b01_00011) begin failures++; $display("FAIL win3_map got=%b%b %b exp=01 00011", ramcs0_b, ramcs1_b, ramadrhi); end
    endtask

    task automatic test_wrap();
        go(16'hBFF0, 1'b0, 8'hFF);
        go(16'hBFF4, 1'b0, 8'h03);
        go(16'hBFF0, 1'b1, 8'h00);
        checks++; if (dout !== 8'h3F) begin failures++; $display("FAIL wrap_readback got=%h exp=3F", dout); end
        go(16'h0000, 1'b1, 8'h00);
        checks++; if ({ramcs0_b, ramcs1_b, ramadrhi} !== 7'b10_11111) begin failures++; $display("FAIL wrap_map got=%b%b %b exp=10 11111", ramcs0_b, ramcs1_b, ramadrhi); end
        go(16'hBFF6, 1'b0, 8'h5A);
        go(16'hBFF6, 1'b1, 8'h00);
        checks++; if (dout !== 8'h00) begin failures++; $display("FAIL off6_read got=%h exp=00", dout); end
    endtask

    task automatic test_wp();
        go(16'hBFF4, 1'b0, 8'h21);
        drive(16'h0000, 1'b0, 8'h55);
        checks++; if (ramwe_b !== 1'b1) begin failures++; $display("FAIL we_low_phase got=%b exp=1", ramwe_b); end
        hi();
        checks++; if (ramwe_b !== 1'b0) begin failures++; $display("FAIL we_unprot got=%b exp=0", ramwe_b); end
        go(16'h4000, 1'b0, 8'hAA);
        checks++; if (ramwe_b !== 1'b1) begin failures++; $display("FAIL we_prot got=%b exp=1", ramwe_b); end
        checks++; if (wp_fault !== 1'b0) begin failures++; $display("FAIL fault_early got=%b exp=0", wp_fault); end
        go(16'h0000, 1'b1, 8'h00);
        checks++; if (wp_fault !== 1'b1) begin failures++; $display("FAIL fault_set got=%b exp=1", wp_fault); end
        go(16'hBFF5, 1'b1, 8'h00);
        checks++; if (dout !== 8'h01) begin failures++; $display("FAIL status_fault got=%h exp=01", dout); end
        go(16'hBFF5, 1'b1, 8'h00);
        checks++; if (dout !== 8'h00) begin failures++; $display("FAIL status_clear got=%h exp=00", dout); end
        checks++; if (wp_fault !== 1'b0) begin failures++; $display("FAIL fault_clear got=%b exp=0", wp_fault); end
    endtask

    task automatic test_hole();
        go(16'hA005, 1'b1, 8'h00);
        checks++; if ({ramcs0_b, ramcs1_b} !== 2'b11) begin failures++; $display("FAIL hole_on_a005 got=%b%b exp=11", ramcs0_b, ramcs1_b); end
        go(16'hBFF2, 1'b1, 8'h00);
        checks++; if ({ramcs0_b, ramcs1_b} !== 2'b11) begin failures++; $display("FAIL hole_on_bff2 got=%b%b exp=11", ramcs0_b, ramcs1_b); end
        checks++; if (dout_oe !== 1'b1 || dout !== 8'h02) begin failures++; $display("FAIL hole_read_hi got=%b %h exp=1 02", dout_oe, dout); end
        @(negedge clk);
        #1;
        checks++; if (dout_oe !== 1'b0) begin failures++; $display("FAIL hole_read_lo got=%b exp=0", dout_oe); end
        go(16'hBFF4, 1'b0, 8'h00);
        go(16'hA005, 1'b1, 8'h00);
        checks++; if ({ramcs0_b, ramcs1_b} !== 2'b11 || map_en !== 1'b0) begin failures++; $display("FAIL hole_off_a005 got=%b%b map=%b exp=11 map=0", ramcs0_b, ramcs1_b, map_en); end
        go(16'hBFF2, 1'b1, 8'h00);
        checks++; if ({ramcs0_b, ramcs1_b} !== 2'b11) begin failures++; $display("FAIL hole_off_bff2 got=%b%b exp=11", ramcs0_b, ramcs1_b); end
    endtask

    task automatic test_reset_mid();
        go(16'hBFF0, 1'b0, 8'h2A);
        go(16'hBFF4, 1'b0, 8'h03);
        go(16'h0000, 1'b1, 8'h00);
        checks++; if ({ramcs0_b, ramcs1_b, ramadrhi} !== 7'b10_01010) begin failures++; $display("FAIL mid_premap got=%b%b %b exp=10 01010", ramcs0_b, ramcs1_b, ramadrhi); end
        go(16'hBFF2, 1'b1, 8'h00);
        checks++; if (dout_oe !== 1'b1) begin failures++; $display("FAIL mid_pre_oe got=%b exp=1", dout_oe); end
        #2 reset_b = 1'b0;
        #1;
        checks++; if (dout_oe !== 1'b0 || dout !== 8'h00 || clk !== 1'b1) begin failures++; $display("FAIL mid_oe_drop got=%b %h clk=%b exp=0 00 clk=1", dout_oe, dout, clk); end
        checks++; if (map_en !== 1'b0) begin failures++; $display("FAIL mid_map_en got=%b exp=0", map_en); end
        adr = 16'h0000;
        #1;
        checks++; if ({ramcs0_b, ramcs1_b, ramadrhi} !== 7'b01_00000) begin failures++; $display("FAIL mid_ident got=%b%b %b exp=01 00000", ramcs0_b, ramcs1_b, ramadrhi); end
        @(negedge clk);
        #1 reset_b = 1'b1;
        go(16'hBFF0, 1'b1, 8'h00);
        checks++; if (dout !== 8'h00) begin failures++; $display("FAIL mid_page0 got=%h exp=00", dout); end
    endtask

    initial begin
        test_reset();
        test_commit();
        test_wrap();
        test_wp();
        test_hole();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
